output_module: RTL and testbench
================================

Name: output_module

Overview:
- Output side of the processor I/O subsystem; the write-direction counterpart of the registered 4-port input block.
- The processor writes a data byte to one of four output ports, chosen by sel_port. Each port buffers writes in a small FIFO.
- Each port presents its data to an external consumer through a valid/ack handshake.
- Reports back-pressure (full) to the processor and records dropped writes (overrun) per port.

Parameters:
- WIDTH, 8, data width of each port and of data_in.
- DEPTH, 2, entries per port FIFO; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  processor write strobe, one write per cycle high.
- sel_port  input  2  target port of the write; also selects which port drives full.
- data_in  input  WIDTH  data to write.
- out_p0  output  WIDTH  head data of port 0.
- out_p1  output  WIDTH  head data of port 1.
- out_p2  output  WIDTH  head data of port 2.
- out_p3  output  WIDTH  head data of port 3.
- out_valid  output  4  bit i high = out_pi holds valid data.
- out_ack  input  4  bit i high = consumer takes head of port i this cycle.
- full  output  1  FIFO of port sel_port is full (combinational on sel_port).
- overrun  output  4  sticky per-port flag: a write was dropped.
- clr_overrun  input  1  clears all overrun bits.

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clk.
  - Reset is synchronous, active-high, and has priority over every other input.
  - Reset empties all FIFOs. After reset: out_valid=0, overrun=0, out_p0..3=0, full=0.
- Write path:
  - A write is performed when we=1, targeting port i=sel_port.
  - If port i is not full, data_in is enqueued at the edge.
  - If port i is full and out_ack[i]=0, the data is dropped and overrun[i] is set at that edge.
  - Writes to other ports are unaffected.
- Read path:
  - out_valid[i] = (count_i != 0). out_pi = head entry when valid, else 0.
  - out_ack[i]=1 with out_valid[i]=1 pops the head at the edge.
  - out_ack[i] while empty is ignored: no state change, no error.
- Latency:
  - A write at edge N into an empty port gives out_valid[i]=1 and out_pi=data during cycle N+1.
  - After a pop at edge N, the next entry (or 0 / invalid) appears in cycle N+1.
  - No combinational path from out_ack to out_pi or out_valid.
- Simultaneous events on the same port:
  - Push and pop when the port is full: both happen, the write is accepted, count unchanged, no overrun.
  - Push and pop when the port is empty: the push happens and the pop is ignored.
  - Push and pop when partially filled: count unchanged, FIFO order preserved.
- Overrun:
  - overrun bits are sticky until clr_overrun or reset.
  - clr_overrun and a new overrun on the same edge: the set wins for that bit; other bits clear.
- Pointers and count:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - full_i = (count_i == DEPTH).
- Ordering: strict FIFO order per port; no reordering across ports is defined or required.

Decomposition:
- Shared package (io_pkg):
  - NUM_PORTS=4, PORT_SEL_W=2, default WIDTH=8.
  - Port index constants P0..P3.
- Sub-module out_port_fifo (WIDTH, DEPTH):
  - Ports: clk, reset, push, din, pop, dout, valid, full, overrun_set.
  - Instantiated four times.
- Top level contains only the sel_port decode of we, the full mux, and the overrun registers.

Test Plan:
- Reset with we=1, sel_port=2, data_in=8'hAA -> next cycle out_valid=4'b0000, out_p2=0, overrun=0, full=0.
- Write 8'h11 to port 1 at edge N -> cycle N+1: out_valid=4'b0010, out_p1=8'h11. Hold out_ack[1]=1 for one cycle -> out_valid[1]=0, out_p1=0.
- Write 8'h01, 8'h02, 8'h03 to port 3 back-to-back, out_ack=0:
  - full=1 (sel_port=3) after the second write.
  - Third write dropped, overrun=4'b1000.
  - Ack twice -> out_p3 reads 8'h01 then 8'h02.
- Fill port 0 with 8'hA0, 8'hA1, then write 8'hA2 with out_ack[0]=1 on the same edge -> overrun[0] stays 0. Subsequent heads are 8'hA1, then 8'hA2.
- overrun=4'b1000 set, then clr_overrun=1 together with a new dropped write to full port 0 -> overrun=4'b0001.
- Interleave writes to ports 0 and 2 with random acks on all ports -> per-port FIFO order matches the scoreboard; out_ack on empty ports causes no change.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and helpers for the processor I/O port blocks.
package io_pkg;

  localparam int unsigned NUM_PORTS     = 4;
  localparam int unsigned PORT_SEL_W    = 2;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [PORT_SEL_W-1:0] port_sel_t;

  localparam port_sel_t P0 = 2'd0;
  localparam port_sel_t P1 = 2'd1;
  localparam port_sel_t P2 = 2'd2;
  localparam port_sel_t P3 = 2'd3;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_sel_t sel);
    logic [NUM_PORTS-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/out_port_fifo.sv
// Per-port output FIFO with valid/ack head interface; a push to a full FIFO is
// accepted only when the head is popped on the same edge.
module out_port_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             overrun_set
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign valid       = (count_q != '0);
  assign full        = (count_q == DepthCnt);
  assign do_pop      = pop && valid;
  assign do_push     = push && (!full || do_pop);
  assign overrun_set = push && full && !do_pop;
  // Gate the head so stale storage never shows while empty.
  assign dout        = valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/output_module.sv
// Four-port processor output block: write decode, full mux and sticky overrun
// flags around one FIFO per port.
module output_module
  import io_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [PORT_SEL_W-1:0] sel_port,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      out_p0,
  output logic [WIDTH-1:0]      out_p1,
  output logic [WIDTH-1:0]      out_p2,
  output logic [WIDTH-1:0]      out_p3,
  output logic [NUM_PORTS-1:0]  out_valid,
  input  logic [NUM_PORTS-1:0]  out_ack,
  output logic                  full,
  output logic [NUM_PORTS-1:0]  overrun,
  input  logic                  clr_overrun
);

  logic [NUM_PORTS-1:0] push_vec;
  logic [NUM_PORTS-1:0] full_vec;
  logic [NUM_PORTS-1:0] ovr_set_vec;
  logic [WIDTH-1:0]     dout_vec [NUM_PORTS];
  logic [NUM_PORTS-1:0] overrun_q, overrun_d;

  assign push_vec = we ? port_onehot(sel_port) : '0;
  assign full     = full_vec[sel_port];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    out_port_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_vec[i]),
      .din        (data_in),
      .pop        (out_ack[i]),
      .dout       (dout_vec[i]),
      .valid      (out_valid[i]),
      .full       (full_vec[i]),
      .overrun_set(ovr_set_vec[i])
    );
  end

  assign out_p0 = dout_vec[P0];
  assign out_p1 = dout_vec[P1];
  assign out_p2 = dout_vec[P2];
  assign out_p3 = dout_vec[P3];

  // A new drop on the clearing edge still sets its bit.
  always_comb begin
    overrun_d = (clr_overrun ? '0 : overrun_q) | ovr_set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= '0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_output_module.sv
// Directed vector table plus a scoreboarded random ack/write run for output_module.
module tb_output_module;

  logic       clk = 1'b0;
  logic       reset, we, clr_overrun;
  logic [1:0] sel_port;
  logic [7:0] data_in;
  logic [7:0] out_p0, out_p1, out_p2, out_p3;
  logic [3:0] out_valid, out_ack, overrun;
  logic       full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_module #(
    .WIDTH(8),
    .DEPTH(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .sel_port   (sel_port),
    .data_in    (data_in),
    .out_p0     (out_p0),
    .out_p1     (out_p1),
    .out_p2     (out_p2),
    .out_p3     (out_p3),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .full       (full),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic [1:0] sel;
    logic [7:0] din;
    logic [3:0] ack;
    logic       clr;
    logic [3:0] e_valid;
    logic [7:0] e_p0, e_p1, e_p2, e_p3;
    logic       e_full;
    logic [3:0] e_ovr;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic w, logic [1:0] s, logic [7:0] d, logic [3:0] a,
                              logic c, logic [3:0] ev, logic [7:0] p0, logic [7:0] p1,
                              logic [7:0] p2, logic [7:0] p3, logic ef, logic [3:0] eo);
    vec_t v;
    v.rst = rst; v.we = w; v.sel = s; v.din = d; v.ack = a; v.clr = c;
    v.e_valid = ev; v.e_p0 = p0; v.e_p1 = p1; v.e_p2 = p2; v.e_p3 = p3;
    v.e_full = ef; v.e_ovr = eo;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] port_data(input int i);
    case (i)
      0: return out_p0;
      1: return out_p1;
      2: return out_p2;
      default: return out_p3;
    endcase
  endfunction

  logic [7:0] sb0 [$];
  logic [7:0] sb2 [$];

  initial begin
    logic [3:0] exp_ovr;
    logic [3:0] exp_valid;
    logic       pop0, pop2;
    int         sz;

    reset = 1'b0; we = 1'b0; clr_overrun = 1'b0; sel_port = 2'd0; data_in = '0; out_ack = '0;

    //            rst we sel din    ack      clr valid    p0     p1     p2     p3     full ovr
    vecs[0]  = mk(1, 1, 2, 8'hAA, 4'b0000, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'b0000);
    vecs[1]  = mk(0, 1, 1, 8'h11, 4'b0000, 0, 4'b0010, 8'h00, 8'h11, 8'h00, 8'h00, 0, 4'b0000);
    vecs[2]  = mk(0, 0, 1, 8'h00, 4'b0010, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'b0000);
    vecs[3]  = mk(0, 1, 3, 8'h01, 4'b0000, 0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h01, 0, 4'b0000);
    vecs[4]  = mk(0, 1, 3, 8'h02, 4'b0000, 0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h01, 1, 4'b0000);
    vecs[5]  = mk(0, 1, 3, 8'h03, 4'b0000, 0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h01, 1, 4'b1000);
    vecs[6]  = mk(0, 0, 3, 8'h00, 4'b1000, 0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h02, 0, 4'b1000);
    vecs[7]  = mk(0, 0, 3, 8'h00, 4'b1000, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'b1000);
    vecs[8]  = mk(0, 1, 0, 8'hA0, 4'b0000, 0, 4'b0001, 8'hA0, 8'h00, 8'h00, 8'h00, 0, 4'b1000);
    vecs[9]  = mk(0, 1, 0, 8'hA1, 4'b0000, 0, 4'b0001, 8'hA0, 8'h00, 8'h00, 8'h00, 1, 4'b1000);
    vecs[10] = mk(0, 1, 0, 8'hA2, 4'b0001, 0, 4'b0001, 8'hA1, 8'h00, 8'h00, 8'h00, 1, 4'b1000);
    vecs[11] = mk(0, 0, 0, 8'h00, 4'b0001, 0, 4'b0001, 8'hA2, 8'h00, 8'h00, 8'h00, 0, 4'b1000);
    vecs[12] = mk(0, 1, 0, 8'hB0, 4'b0000, 0, 4'b0001, 8'hA2, 8'h00, 8'h00, 8'h00, 1, 4'b1000);
    vecs[13] = mk(0, 1, 0, 8'hB1, 4'b0000, 1, 4'b0001, 8'hA2, 8'h00, 8'h00, 8'h00, 1, 4'b0001);
    vecs[14] = mk(0, 0, 2, 8'h00, 4'b1110, 0, 4'b0001, 8'hA2, 8'h00, 8'h00, 8'h00, 0, 4'b0001);
    vecs[15] = mk(0, 0, 0, 8'h00, 4'b0000, 1, 4'b0001, 8'hA2, 8'h00, 8'h00, 8'h00, 1, 4'b0000);
    vecs[16] = mk(0, 1, 1, 8'hC1, 4'b0010, 0, 4'b0011, 8'hA2, 8'hC1, 8'h00, 8'h00, 0, 4'b0000);
    vecs[17] = mk(1, 1, 0, 8'hFF, 4'b0001, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'b0000);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; we = vecs[i].we; sel_port = vecs[i].sel; data_in = vecs[i].din;
      out_ack = vecs[i].ack; clr_overrun = vecs[i].clr;
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
      chk("out_p0", i, 32'(out_p0), 32'(vecs[i].e_p0));
      chk("out_p1", i, 32'(out_p1), 32'(vecs[i].e_p1));
      chk("out_p2", i, 32'(out_p2), 32'(vecs[i].e_p2));
      chk("out_p3", i, 32'(out_p3), 32'(vecs[i].e_p3));
      chk("full", i, 32'(full), 32'(vecs[i].e_full));
      chk("overrun", i, 32'(overrun), 32'(vecs[i].e_ovr));
    end

    // Random interleave on ports 0 and 2, random acks everywhere, queue scoreboard.
    @(negedge clk);
    reset = 1'b1; we = 1'b0; out_ack = '0; clr_overrun = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_ovr = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      we       = 1'($urandom_range(0, 1));
      sel_port = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0;
      data_in  = 8'($urandom);
      out_ack  = 4'($urandom);
      #1;
      sz = (sel_port == 2'd0) ? sb0.size() : sb2.size();
      chk("rand_full", c, 32'(full), 32'(sz == 2));

      pop0 = out_ack[0] && (sb0.size() != 0);
      pop2 = out_ack[2] && (sb2.size() != 0);
      if (pop0) void'(sb0.pop_front());
      if (pop2) void'(sb2.pop_front());
      if (we) begin
        if (sel_port == 2'd0) begin
          if (sz < 2 || pop0) sb0.push_back(data_in);
          else exp_ovr[0] = 1'b1;
        end else begin
          if (sz < 2 || pop2) sb2.push_back(data_in);
          else exp_ovr[2] = 1'b1;
        end
      end

      @(posedge clk);
      #1;
      exp_valid = {1'b0, sb2.size() != 0, 1'b0, sb0.size() != 0};
      chk("rand_valid", c, 32'(out_valid), 32'(exp_valid));
      chk("rand_p0", c, 32'(port_data(0)), 32'((sb0.size() != 0) ? sb0[0] : 8'h00));
      chk("rand_p1", c, 32'(port_data(1)), 32'h0);
      chk("rand_p2", c, 32'(port_data(2)), 32'((sb2.size() != 0) ? sb2[0] : 8'h00));
      chk("rand_p3", c, 32'(port_data(3)), 32'h0);
      chk("rand_ovr", c, 32'(overrun), 32'(exp_ovr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
